// File: rtl/hazard_pkg.sv
// Shared types and default latency constants for the hazard scoreboard.
package hazard_pkg;

  localparam int unsigned DEF_REG_W    = 5;
  localparam int unsigned DEF_ALU_LAT  = 2;
  localparam int unsigned DEF_LOAD_LAT = 3;
  localparam int unsigned DEF_MD_LAT   = 32;
  localparam int unsigned DEF_CNT_W    = 16;
  localparam int unsigned PEND_W       = 3;
  localparam int unsigned MD_CNT_W     = 8;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_M  = 2'd1,
    FWD_W  = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/reg_pend_table.sv
// Per-register countdown of cycles until a result becomes forwardable.
// Entry 0 is never written, so it always reads zero.
module reg_pend_table
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W = DEF_REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [REG_W-1:0]  i_waddr,
  input  logic [PEND_W-1:0] i_wdata,
  input  logic [REG_W-1:0]  i_raddr0,
  input  logic [REG_W-1:0]  i_raddr1,
  output logic [PEND_W-1:0] o_rdata0_c,
  output logic [PEND_W-1:0] o_rdata1_c
);

  localparam int unsigned NREGS = 1 << REG_W;

  logic [PEND_W-1:0] r_pend [NREGS];

  // A write to an entry overrides that entry's decrement in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < NREGS; r++) r_pend[r] <= '0;
    end else begin
      r_pend[0] <= '0;
      for (int unsigned r = 1; r < NREGS; r++) begin
        if (i_we && (i_waddr == REG_W'(r))) begin
          r_pend[r] <= i_wdata;
        end else if (r_pend[r] != '0) begin
          r_pend[r] <= r_pend[r] - PEND_W'(1);
        end
      end
    end
  end

  assign o_rdata0_c = r_pend[i_raddr0];
  assign o_rdata1_c = r_pend[i_raddr1];

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: pending-result scoreboard, mult/div busy tracking,
// stall generation, operand forwarding selects and a saturating stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W    = DEF_REG_W,
  parameter int unsigned ALU_LAT  = DEF_ALU_LAT,
  parameter int unsigned LOAD_LAT = DEF_LOAD_LAT,
  parameter int unsigned MD_LAT   = DEF_MD_LAT,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rsD,
  input  logic [REG_W-1:0] rtD,
  input  logic             useRsD,
  input  logic             useRtD,
  input  logic [REG_W-1:0] dstD,
  input  logic             wrD,
  input  logic             loadD,
  input  logic             mdD,
  input  logic             mfD,
  input  logic             BranchD,
  input  logic             jrD,
  input  logic [REG_W-1:0] rsE,
  input  logic [REG_W-1:0] rtE,
  input  logic [REG_W-1:0] rdM,
  input  logic [REG_W-1:0] rdW,
  input  logic             regwriteM,
  input  logic             regwriteW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_count
);

  logic [PEND_W-1:0]   w_pend_rs;
  logic [PEND_W-1:0]   w_pend_rt;
  logic [PEND_W-1:0]   w_pend_wdata;
  logic                w_pend_we;
  logic                w_issue;
  logic                w_stall;
  logic                w_dcons;
  logic                w_lu_stall;
  logic                w_br_stall;
  logic                w_md_stall;
  logic                w_md_busy;
  fwd_sel_t            w_fwd_ae;
  fwd_sel_t            w_fwd_be;
  logic [MD_CNT_W-1:0] r_md_cnt;
  logic [CNT_W-1:0]    r_stall_cnt;

  assign w_issue      = ~w_stall;
  assign w_pend_we    = w_issue & wrD & (dstD != '0);
  assign w_pend_wdata = loadD ? PEND_W'(LOAD_LAT) : PEND_W'(ALU_LAT);

  reg_pend_table #(
    .REG_W (REG_W)
  ) u_pend (
    .clk        (clk),
    .reset      (reset),
    .i_we       (w_pend_we),
    .i_waddr    (dstD),
    .i_wdata    (w_pend_wdata),
    .i_raddr0   (rsD),
    .i_raddr1   (rtD),
    .o_rdata0_c (w_pend_rs),
    .o_rdata1_c (w_pend_rt)
  );

  // Branches and jr need the operand in D; everything else can take it in E.
  assign w_dcons    = BranchD | jrD;
  assign w_lu_stall = ~w_dcons & ((useRsD & (w_pend_rs > PEND_W'(1))) |
                                  (useRtD & (w_pend_rt > PEND_W'(1))));
  assign w_br_stall = (w_dcons & useRsD & (w_pend_rs != '0)) |
                      (BranchD & useRtD & (w_pend_rt != '0));
  assign w_md_busy  = (r_md_cnt != '0);
  assign w_md_stall = (mdD | mfD) & w_md_busy;
  assign w_stall    = w_lu_stall | w_br_stall | w_md_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_md_cnt <= '0;
    end else if (w_issue && mdD) begin
      r_md_cnt <= MD_CNT_W'(MD_LAT);
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - MD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // M-stage match takes priority over W-stage match.
  always_comb begin
    w_fwd_ae = FWD_RF;
    w_fwd_be = FWD_RF;
    if ((rsE != '0) && regwriteM && (rsE == rdM)) begin
      w_fwd_ae = FWD_M;
    end else if ((rsE != '0) && regwriteW && (rsE == rdW)) begin
      w_fwd_ae = FWD_W;
    end
    if ((rtE != '0) && regwriteM && (rtE == rdM)) begin
      w_fwd_be = FWD_M;
    end else if ((rtE != '0) && regwriteW && (rtE == rdW)) begin
      w_fwd_be = FWD_W;
    end
  end

  assign ForwardAE   = w_fwd_ae;
  assign ForwardBE   = w_fwd_be;
  assign ForwardAD   = (rsD != '0) & regwriteM & (rsD == rdM);
  assign ForwardBD   = (rtD != '0) & regwriteM & (rtD == rdM);
  assign StallF      = w_stall;
  assign StallD      = w_stall;
  assign FlushE      = w_stall;
  assign md_busy     = w_md_busy;
  assign stall_count = r_stall_cnt;

endmodule
